rv_read_scheduler: RTL and testbench
====================================

# rv_read_scheduler

Round-robin scheduler that shares one ready-valid read bus among `NUM_CH` device-side data sources, such as trace-buffer status, configuration readback and trace data registers. Each source raises a request pulse when its data changes. The scheduler queues these requests, grants one channel at a time and serializes the channel's `DATA_WIDTH`-bit word onto the `BUS_WIDTH`-bit bus. The word is preceded by a header beat that carries the channel index. It sits between the per-register device logic and the host-facing ready-valid read port.

## Interface
- `NUM_CH`, default 4: number of requesting channels, ≥2; `$clog2(NUM_CH)` ≤ `BUS_WIDTH`.
- `DATA_WIDTH`, default 16: width of each channel's data word.
- `BUS_WIDTH`, default 8: width of the read bus; `BEATS = ceil(DATA_WIDTH/BUS_WIDTH)`.

Ports:
- `CLK_I` in, 1: single clock; all logic on its rising edge.
- `RST_I` in, 1: reset, synchronous, active-high.
- `REQ_I` in, `NUM_CH`: per-channel request pulse, meaning "data changed".
- `DATA_I` in, `NUM_CH*DATA_WIDTH`: channel i's data is in bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `ACK_O` out, `NUM_CH`: one-cycle pulse when a channel's last beat has been accepted.
- `READ_READY_I` in, 1: bus sink ready.
- `READ_VALID_O` out, 1: bus beat valid.
- `READ_DATA_O` out, `BUS_WIDTH`: bus beat.
- `BUSY_O` out, 1: high when the state is not IDLE.

## Operation
- `pending[NUM_CH]` register: bit i is set when `REQ_I[i]` is 1.
- Bit i is cleared when channel i is captured.
- If `REQ_I[i]` is 1 in the same cycle channel i is captured, bit i stays set and the request is queued again.
- FSM states:
  - **IDLE:** if `pending` is nonzero, pick the first set bit searching upward from `last_grant+1` with wrap-around. On the clock edge:
    - capture that channel's `DATA_I` slice into the shift register;
    - store the channel in `cur_ch` and `last_grant`;
    - clear its pending bit;
    - go to HEADER.
  - **HEADER:** `READ_DATA_O` is `cur_ch`, zero-extended to `BUS_WIDTH`. On handshake (`READ_VALID_O & READ_READY_I`): set `beat` to 0 and go to DATA.
  - **DATA:** `READ_DATA_O` is bits `[beat*BUS_WIDTH +: BUS_WIDTH]` of the captured word, LSB beat first. The upper bits of the last beat are zero-padded when `DATA_WIDTH` is not a multiple of `BUS_WIDTH`. On handshake:
    - if `beat == BEATS-1`: pulse `ACK_O[cur_ch]` and go to IDLE;
    - otherwise increment `beat`.
- `READ_VALID_O` is 1 in HEADER and DATA, and 0 in IDLE.
- `READ_DATA_O` is 0 in IDLE.
- Data is sampled once, at capture. Changes on `DATA_I` during a transfer do not affect the beats already in flight.
- Multiple simultaneous requests are served one transfer each, in round-robin order.
- A request for the channel currently being transferred is served again later with freshly sampled data.

## Timing
- Reset values:
  - `READ_VALID_O`, `READ_DATA_O`, `ACK_O`, `BUSY_O` all 0;
  - `pending` 0;
  - `last_grant = NUM_CH-1`, so channel 0 has first priority;
  - state IDLE.
- Latency with `REQ_I[i]` high in cycle t and no other traffic:
  - `pending[i]` is set from cycle t+1;
  - capture happens at the end of t+1;
  - the header is valid from cycle t+2.
- A full transfer with `READY` held high takes `1+BEATS` valid cycles, followed by 1 IDLE bubble before the next header.
- `ACK_O[i]` is registered. It is high for exactly the one cycle after the last beat's handshake, concurrent with IDLE.
- Backpressure: while `READ_VALID_O` is 1 and `READY` is 0, `READ_DATA_O`, state and `beat` hold stable. `VALID` never drops until the handshake.
- Reset mid-transfer:
  - the next cycle shows reset values;
  - the partial transfer is discarded with no `ACK`;
  - all pending requests are dropped.
- `REQ_I` arriving during reset is ignored.

## Test plan
All scenarios use `NUM_CH=4`, `DATA_WIDTH=16`, `BUS_WIDTH=8` unless stated otherwise.
- **Single request:** `REQ_I=0b0100` for one cycle, ch2 data `0xBEEF`, `READY=1` → valid beats `0x02`, `0xEF`, `0xBE` starting 2 cycles after `REQ`. `ACK_O=0b0100` for 1 cycle after the `0xBE` handshake. `BUSY_O` is high for 3 cycles.
- **Backpressure:** as above, but `READY=0` for 3 cycles during HEADER and 2 cycles during the `0xEF` beat → data and `VALID` are held stable. Same beat sequence, with no duplicate or dropped beats.
- **Round-robin:**
  - After reset, `REQ_I=0b1111` for one cycle → headers appear in order 0, 1, 2, 3, each followed by its data. There is 1 bubble between transfers.
  - Next, with `last_grant=1`, `REQ_I=0b1001` → order 3, then 0.
- **Re-request during transfer:** ch1 data `0x1111` is captured. During its DATA beats, ch1 data changes to `0x2222` and `REQ_I=0b0010` is pulsed → the first transfer sends `0x11`, `0x11`. A second transfer then sends `0x01`, `0x22`, `0x22`, and `ACK_O[1]` pulses twice.
- **Reset mid-transfer:** `RST_I` is pulsed after the header handshake, with ch3 also pending → `VALID` is 0 from the next cycle, with no `ACK`. After reset is released with no new `REQ`, the bus stays idle (ch3 was dropped).
- **Padding:** with `DATA_WIDTH=12`, ch0 data `0xABC` → beats `0x00`, `0xBC`, `0x0A`.

Source files
------------

// File: rtl/rv_read_scheduler.sv
// rv_read_scheduler: round-robin arbiter serializing per-channel data words onto a ready-valid bus with a channel header beat.
module rv_read_scheduler #(
  parameter int NUM_CH = 4,
  parameter int DATA_WIDTH = 16,
  parameter int BUS_WIDTH = 8
) (
  input  logic                         CLK_I,
  input  logic                         RST_I,
  input  logic [NUM_CH-1:0]            REQ_I,
  input  logic [NUM_CH*DATA_WIDTH-1:0] DATA_I,
  output logic [NUM_CH-1:0]            ACK_O,
  input  logic                         READ_READY_I,
  output logic                         READ_VALID_O,
  output logic [BUS_WIDTH-1:0]         READ_DATA_O,
  output logic                         BUSY_O
);
  localparam int BEATS = (DATA_WIDTH + BUS_WIDTH - 1) / BUS_WIDTH;
  localparam int SW = BEATS * BUS_WIDTH;
  localparam int CW = $clog2(NUM_CH);
  localparam int BTW = BEATS > 1 ? $clog2(BEATS) : 1;
  typedef enum logic [1:0] {IDLE, HEADER, DATA} state_t;
  state_t state, state_nx;
  logic [NUM_CH-1:0] pending;
  logic [CW-1:0] last_grant, cur_ch, pick;
  logic [BTW-1:0] beat;
  logic [SW-1:0] sr;
  logic hs, found, last_beat, capture;
  int idx;
  assign hs = READ_VALID_O & READ_READY_I;
  assign last_beat = beat == BTW'(BEATS - 1);
  assign capture = (state == IDLE) && found;
  // descending scan so the nearest set bit after last_grant wins
  always_comb begin
    pick = last_grant;
    found = 1'b0;
    idx = 0;
    for (int k = NUM_CH; k >= 1; k--) begin
      idx = int'(last_grant) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (pending[CW'(idx)]) begin
        pick = CW'(idx);
        found = 1'b1;
      end
    end
  end
  always_comb begin
    state_nx = state == IDLE   ? (found ? HEADER : IDLE) :
               state == HEADER ? (hs ? DATA : HEADER) :
                                 (hs && last_beat ? IDLE : DATA);
    READ_VALID_O = state != IDLE;
    BUSY_O = state != IDLE;
    READ_DATA_O = state == HEADER ? BUS_WIDTH'(cur_ch) :
                  state == DATA   ? sr[BUS_WIDTH-1:0] : '0;
  end
  always_ff @(posedge CLK_I) begin
    if (RST_I) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      pending <= '0;
      last_grant <= CW'(NUM_CH - 1);
      cur_ch <= '0;
      beat <= '0;
      sr <= '0;
      ACK_O <= '0;
    end else begin
      ACK_O <= '0;
      pending <= (pending & ~(capture ? NUM_CH'(1) << pick : '0)) | REQ_I;
      if (capture) begin
        sr <= SW'(DATA_I[pick*DATA_WIDTH +: DATA_WIDTH]);
        cur_ch <= pick;
        last_grant <= pick;
      end
      if (state == HEADER && hs) beat <= '0;
      if (state == DATA && hs) begin
        if (last_beat) ACK_O[cur_ch] <= 1'b1;
        else begin
          beat <= beat + 1'b1;
          sr <= sr >> BUS_WIDTH;
        end
      end
    end
  end
endmodule

// File: tb/tb_rv_read_scheduler.sv
// tb_rv_read_scheduler: directed scenarios plus random traffic against a transaction-queue reference model.
module tb_rv_read_scheduler;
  localparam int N = 4, DW = 16, BW = 8, BEATS = 2;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;
  logic [N-1:0] req = '0;
  logic [N*DW-1:0] data = '0;
  logic rdy = 1'b1;
  logic [N-1:0] ack;
  logic vld, busy;
  logic [BW-1:0] rdata;
  logic [N-1:0] p_req = '0;
  logic [N*12-1:0] p_data = '0;
  logic p_rdy = 1'b1;
  logic [N-1:0] p_ack;
  logic p_vld, p_busy;
  logic [BW-1:0] p_rdata;

  rv_read_scheduler #(.NUM_CH(N), .DATA_WIDTH(DW), .BUS_WIDTH(BW)) dut (
    .CLK_I(clk), .RST_I(rst), .REQ_I(req), .DATA_I(data), .ACK_O(ack),
    .READ_READY_I(rdy), .READ_VALID_O(vld), .READ_DATA_O(rdata), .BUSY_O(busy));
  rv_read_scheduler #(.NUM_CH(N), .DATA_WIDTH(12), .BUS_WIDTH(BW)) dut_pad (
    .CLK_I(clk), .RST_I(rst), .REQ_I(p_req), .DATA_I(p_data), .ACK_O(p_ack),
    .READ_READY_I(p_rdy), .READ_VALID_O(p_vld), .READ_DATA_O(p_rdata), .BUSY_O(p_busy));

  int n_checks = 0, n_fail = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Reference: pending set, round-robin pointer, and the queue of beats still owed on the bus.
  int unsigned exp_q[$];
  logic [N-1:0] m_pend = '0, m_ack = '0;
  int m_last = N - 1, m_cur = 0, m_sel;
  bit m_found;
  logic [DW-1:0] m_word;
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_pend = '0;
      m_ack = '0;
      m_last = N - 1;
    end else begin
      check("ack", ack, m_ack);
      m_ack = '0;
      check("busy", busy, exp_q.size() != 0);
      check("valid", vld, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        check("beat", rdata, exp_q[0]);
        if (rdy) begin
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) m_ack[m_cur] = 1'b1;
        end
      end else begin
        check("idle_data", rdata, 0);
        m_found = 0;
        m_sel = 0;
        for (int k = 1; k <= N; k++)
          if (!m_found && m_pend[(m_last + k) % N]) begin
            m_found = 1;
            m_sel = (m_last + k) % N;
          end
        if (m_found) begin
          m_last = m_sel;
          m_cur = m_sel;
          m_pend[m_sel] = 1'b0;
          m_word = data[m_sel*DW +: DW];
          exp_q.push_back(m_sel);
          for (int b = 0; b < BEATS; b++) exp_q.push_back((m_word >> (b * BW)) & 'hFF);
        end
      end
      m_pend = m_pend | req;
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [BW-1:0] pad_beats[3];
  int pad_got;
  int ack1_cnt = 0;
  always @(negedge clk) if (!rst && ack[1]) ack1_cnt++;

  initial begin
    cyc(2);
    rst = 0;
    cyc(1);
    // single request, ch2 = BEEF
    data[2*DW +: DW] = 16'hBEEF;
    req = 4'b0100; cyc(1); req = '0; cyc(6);
    // backpressure on header and first data beat
    req = 4'b0100; cyc(1); req = '0; cyc(1);
    rdy = 0; cyc(3); rdy = 1; cyc(1);
    rdy = 0; cyc(2); rdy = 1; cyc(4);
    // round robin from reset
    rst = 1; cyc(1); rst = 0;
    data = 64'h3333_2222_1111_0000;
    req = 4'b1111; cyc(1); req = '0; cyc(16);
    req = 4'b0010; cyc(1); req = '0; cyc(6);
    req = 4'b1001; cyc(1); req = '0; cyc(10);
    // re-request ch1 during its own transfer
    ack1_cnt = 0;
    data[DW +: DW] = 16'h1111;
    req = 4'b0010; cyc(1); req = '0; cyc(2);
    data[DW +: DW] = 16'h2222;
    req = 4'b0010; cyc(1); req = '0; cyc(8);
    check("ack1_twice", ack1_cnt, 2);
    // reset mid-transfer with ch3 pending
    req = 4'b1001; cyc(1); req = '0; cyc(2);
    rst = 1; cyc(1); rst = 0; cyc(8);
    // padding: 12-bit word over 8-bit bus
    p_data[11:0] = 12'hABC;
    p_req = 4'b0001; cyc(1); p_req = '0;
    pad_got = 0;
    for (int i = 0; i < 20 && pad_got < 3; i++) begin
      @(negedge clk);
      if (p_vld && p_rdy) begin
        pad_beats[pad_got] = p_rdata;
        pad_got++;
      end
    end
    check("pad_count", pad_got, 3);
    check("pad_hdr", pad_beats[0], 8'h00);
    check("pad_lo", pad_beats[1], 8'hBC);
    check("pad_hi", pad_beats[2], 8'h0A);
    cyc(3);
    // random traffic with backpressure and occasional reset
    for (int i = 0; i < 3000; i++) begin
      req = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      if ($urandom_range(0, 3) == 0) data = {$urandom, $urandom};
      rdy = $urandom_range(0, 3) != 0;
      rst = $urandom_range(0, 299) == 0;
      cyc(1);
    end
    rst = 0; req = '0; rdy = 1;
    cyc(40);
    check("drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
